// File: rtl/main_mem_responder.sv
// main_mem_responder: backing byte array below the cache; serves 4-byte block reads and write-backs
// Ports:
//   i_clock      clock, all state on posedge
//   i_reset_n    asynchronous active-low reset (array contents are kept)
//   i_addr_mem   block address from the cache, low 2 bits ignored
//   i_rd_mem     block read request, held until ready is seen
//   i_wr_mem     write strobe, k+1 means byte k is on i_wmem_byte, 0 means none
//   i_wmem_byte  write data byte
//   o_data_mem   registered read data byte
//   o_data_oe    high while o_data_mem carries a read byte
//   o_ready_mem  memory ready / read data about to stream
//   o_proto_err  one-cycle pulse, registered, after a bad write strobe
module main_mem_responder #(
    parameter int AWIDTH     = 9,
    parameter int DWIDTH     = 8,
    parameter int BLOCKSIZE  = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [AWIDTH-1:0] i_addr_mem,
    input  logic              i_rd_mem,
    input  logic [3:0]        i_wr_mem,
    input  logic [DWIDTH-1:0] i_wmem_byte,
    output logic [DWIDTH-1:0] o_data_mem,
    output logic              o_data_oe,
    output logic              o_ready_mem,
    output logic              o_proto_err
);
    localparam int BW = $clog2(BLOCKSIZE);
    localparam int LW = $clog2(RD_LATENCY + 1);
    localparam int MEMDEPTH = 2 ** AWIDTH;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_READY, RD_BURST, WR_COLLECT, WR_COMMIT} state_t;

    state_t                 r_state, w_next;
    logic [AWIDTH-BW-1:0]   r_blk;
    logic [BW-1:0]          r_bcnt;
    logic [LW-1:0]          r_lat;
    logic [DWIDTH-1:0]      r_data;
    logic                   r_oe;
    logic                   r_proto_err;
    logic [DWIDTH-1:0]      r_mem [MEMDEPTH];
    logic [DWIDTH-1:0]      r_shadow [BLOCKSIZE];
    logic                   w_err;
    logic                   w_ready;
    logic                   w_wr_ok;
    logic                   w_shadow_we;
    logic [BW-1:0]          w_sidx;
    logic                   w_unused;

    assign w_unused    = ^i_addr_mem[BW-1:0];
    assign w_wr_ok     = (i_wr_mem == 4'(r_bcnt) + 4'd1);
    assign w_shadow_we = (r_state == IDLE && i_wr_mem == 4'd1) || (r_state == WR_COLLECT && w_wr_ok);
    // after an aborted write r_bcnt may be stale on the first idle cycle, so byte 0 is forced
    assign w_sidx      = (r_state == IDLE) ? '0 : r_bcnt;

    assign o_data_mem  = r_data;
    assign o_data_oe   = r_oe;
    assign o_ready_mem = w_ready;
    assign o_proto_err = r_proto_err;

    always_comb begin
        w_next  = r_state;
        w_err   = 1'b0;
        w_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = ~i_rd_mem & (i_wr_mem == 4'd0);
                if (i_wr_mem == 4'd1) w_next = WR_COLLECT;
                else if (i_wr_mem != 4'd0) w_err = 1'b1;
                else if (i_rd_mem) w_next = RD_WAIT;
            end
            RD_WAIT:  w_next = (r_lat == LW'(RD_LATENCY - 1)) ? RD_READY : RD_WAIT;
            RD_READY: begin
                w_ready = 1'b1;
                w_next  = RD_BURST;
            end
            RD_BURST: w_next = (r_bcnt == '0) ? IDLE : RD_BURST;
            WR_COLLECT: begin
                if (w_wr_ok) w_next = (r_bcnt == '1) ? WR_COMMIT : WR_COLLECT;
                else if (i_wr_mem != 4'd0) begin
                    w_err  = 1'b1;
                    w_next = IDLE;
                end
            end
            WR_COMMIT: begin
                w_ready = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_blk       <= '0;
            r_bcnt      <= '0;
            r_lat       <= '0;
            r_data      <= '0;
            r_oe        <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_proto_err <= w_err;
            case (r_state)
                IDLE: begin
                    r_blk  <= i_addr_mem[AWIDTH-1:BW];
                    r_lat  <= '0;
                    r_bcnt <= (i_wr_mem == 4'd1) ? BW'(1) : '0;
                end
                RD_WAIT: r_lat <= r_lat + 1'b1;
                // RD_READY loads byte 0; the burst loads 1..3, then the wrapped count ends it
                RD_READY, RD_BURST: begin
                    if (r_state == RD_BURST && r_bcnt == '0) r_oe <= 1'b0;
                    else begin
                        r_data <= r_mem[{r_blk, r_bcnt}];
                        r_oe   <= 1'b1;
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                WR_COLLECT: if (w_wr_ok) r_bcnt <= r_bcnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_shadow_we) r_shadow[w_sidx] <= i_wmem_byte;
        if (r_state == WR_COMMIT)
            for (int k = 0; k < BLOCKSIZE; k++) r_mem[{r_blk, BW'(k)}] <= r_shadow[k];
    end
endmodule
